mem_stage_sram: RTL and testbench

- Consumer end of the execute-stage results: takes ALU result, store data and control bits from EXE and performs the data-memory access.
- Drives a 16-bit external SRAM, so each 32-bit word takes two halfword phases.
- Asserts freeze to stall the upstream pipeline during an access.
- Registers the MEM→WB pipeline outputs.

---
 rtl/mem_stage_sram.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage_sram.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage: performs data-memory loads/stores on a 16-bit async SRAM as two halfword phases.
// Optional build macro MEM_STAGE_ALIGN_CHECK_EN adds mem_fault and rejects misaligned/below-base accesses.
module mem_stage_sram #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_ADDR_W = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_enable_in,
    input  logic                   mem_read_in,
    input  logic                   mem_write_in,
    input  logic [31:0]            alu_res_in,
    input  logic [31:0]            val_rm_in,
    input  logic [3:0]             dest_in,
    output logic                   freeze,
    output logic                   wb_enable_out,
    output logic                   mem_read_out,
    output logic [31:0]            alu_res_out,
    output logic [31:0]            mem_data_out,
    output logic [3:0]             dest_out,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic [1:0]             dbg_state
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    ,
    output logic                   mem_fault
`endif
);

    // Stall handshake: while freeze=1 EXE holds every *_in stable; the stage
    // consumes them on the first rising edge at which freeze=0.
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SRAM_ADDR_W-2:0] word_addr_q, word_addr_d;
    logic [31:0]            store_q, store_d;
    logic                   is_write_q, is_write_d;
    logic [31:0]            read_q, read_d;
    logic                   wb_enable_q, wb_enable_d;
    logic                   mem_read_q, mem_read_d;
    logic [31:0]            alu_res_q, alu_res_d;
    logic [31:0]            mem_data_q, mem_data_d;
    logic [3:0]             dest_q, dest_d;
    logic                   mem_fault_q, mem_fault_d;

    logic [31:0] offset;
    logic        mem_op, bad_op, start, phase_last, load_pipe;
    logic        unused_offset;

    assign offset        = alu_res_in - BASE_ADDR;
    assign unused_offset = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};
    assign mem_op        = mem_read_in | mem_write_in;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign bad_op = mem_op & ((alu_res_in[1:0] != 2'b00) | (alu_res_in < BASE_ADDR));
`else
    assign bad_op = 1'b0;
`endif
    // The detection cycle doubles as the first LO phase cycle, so LO state starts at count 1.
    assign start      = (state_q == S_IDLE) & mem_op & ~bad_op;
    assign phase_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_addr_d = word_addr_q;
        store_d     = store_q;
        is_write_d  = is_write_q;
        read_d      = read_q;
        wb_enable_d = wb_enable_q;
        mem_read_d  = mem_read_q;
        alu_res_d   = alu_res_q;
        mem_data_d  = mem_data_q;
        dest_d      = dest_q;
        mem_fault_d = 1'b0;
        load_pipe   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LO;
                    cnt_d       = CNT_W'(1);
                    word_addr_d = offset[SRAM_ADDR_W:2];
                    store_d     = val_rm_in;
                    is_write_d  = mem_write_in;
                end else begin
                    load_pipe = 1'b1;
                end
            end
            S_LO: begin
                if (phase_last) begin
                    if (!is_write_q) read_d[15:0] = sram_dq_in;
                    state_d = S_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HI: begin
                if (phase_last) begin
                    if (!is_write_q) read_d[31:16] = sram_dq_in;
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                load_pipe = 1'b1;
                if (!is_write_q) mem_data_d = read_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (load_pipe) begin
            wb_enable_d = wb_enable_in;
            mem_read_d  = mem_read_in & ~mem_write_in;
            alu_res_d   = alu_res_in;
            dest_d      = dest_in;
        end
        if (state_q == S_IDLE && bad_op) begin
            wb_enable_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_fault_d = 1'b1;
        end
    end

    // Strobes are gated by rst so a reset mid-access releases the bus at once.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        if (start && rst) begin
            sram_addr = {offset[SRAM_ADDR_W:2], 1'b0};
            if (mem_write_in) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = val_rm_in[15:0];
                sram_we_n   = 1'b0;
            end else begin
                sram_oe_n = 1'b0;
            end
        end else if (state_q == S_LO || state_q == S_HI) begin
            sram_addr = {word_addr_q, (state_q == S_HI)};
            if (is_write_q) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state_q == S_HI) ? store_q[31:16] : store_q[15:0];
                sram_we_n   = phase_last;
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

    assign freeze = rst & (start | (state_q == S_LO) | (state_q == S_HI));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            word_addr_q <= '0;
            store_q     <= '0;
            is_write_q  <= 1'b0;
            read_q      <= '0;
            wb_enable_q <= 1'b0;
            mem_read_q  <= 1'b0;
            alu_res_q   <= '0;
            mem_data_q  <= '0;
            dest_q      <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_addr_q <= word_addr_d;
            store_q     <= store_d;
            is_write_q  <= is_write_d;
            read_q      <= read_d;
            wb_enable_q <= wb_enable_d;
            mem_read_q  <= mem_read_d;
            alu_res_q   <= alu_res_d;
            mem_data_q  <= mem_data_d;
            dest_q      <= dest_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    assign wb_enable_out = wb_enable_q;
    assign mem_read_out  = mem_read_q;
    assign alu_res_out   = alu_res_q;
    assign mem_data_out  = mem_data_q;
    assign dest_out      = dest_q;
    assign dbg_state     = state_q;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign mem_fault = mem_fault_q;
`else
    logic unused_fault;
    assign unused_fault = mem_fault_q;
`endif

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed + random bench for mem_stage_sram with a halfword SRAM model and an expected-result queue.
// Build with MEM_STAGE_ALIGN_CHECK_EN defined to also exercise the fault path.
module tb_mem_stage_sram;
  localparam int W = 2;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int AW = 18;

  logic clk, rst;
  logic wb_enable_in, mem_read_in, mem_write_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic [3:0] dest_in;
  logic freeze, wb_enable_out, mem_read_out;
  logic [31:0] alu_res_out, mem_data_out;
  logic [3:0] dest_out;
  logic [AW-1:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic sram_dq_oe, sram_we_n, sram_oe_n;
  logic [1:0] dbg_state;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic mem_fault;
`endif

  mem_stage_sram #(.BASE_ADDR(BASE), .SRAM_ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .wb_enable_in(wb_enable_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .freeze(freeze), .wb_enable_out(wb_enable_out), .mem_read_out(mem_read_out),
    .alu_res_out(alu_res_out), .mem_data_out(mem_data_out), .dest_out(dest_out),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .dbg_state(dbg_state)
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    , .mem_fault(mem_fault)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // halfword SRAM model
  logic [15:0] sram_mem [0:(1<<AW)-1];
  assign sram_dq_in = !sram_oe_n ? sram_mem[sram_addr] : 16'h0000;
  always @(posedge clk)
    if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_oe ? sram_dq_out : 16'h0bad;

  // scoreboard: {wb, mem_read, alu_res, mem_data, dest}
  logic [69:0] exp_q[$];
  logic [31:0] model_mem [int];
  logic [31:0] last_data, last_alu;
  int pass_cnt, fail_cnt, check_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) % (32'd1 << (AW - 1)));
  endfunction

  task automatic idle_inputs();
    wb_enable_in = 0; mem_read_in = 0; mem_write_in = 0;
    alu_res_in = 0; val_rm_in = 0; dest_in = 0;
  endtask

  // driver: present one instruction just after a rising edge, follow it until consumed
  task automatic do_op(input logic wb, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] dest);
    logic is_mem, flt;
    logic [31:0] data;
    logic [69:0] e;
    logic [AW-1:0] a_lo;
    logic [AW-1:0] t_addr [48];
    logic [15:0] t_dq [48];
    logic t_we [48];
    logic t_oe [48];
    logic t_dqoe [48];
    logic [31:0] t_aluo [48];
    int n;
    is_mem = rd | wr;
    flt = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    flt = is_mem && (alu[1:0] != 2'b00 || alu < BASE);
`endif
    if (flt) is_mem = 1'b0;
    data = last_data;
    if (is_mem && wr) model_mem[widx(alu)] = rm;
    else if (is_mem && rd) data = model_mem.exists(widx(alu)) ? model_mem[widx(alu)] : 32'h0;
    a_lo = AW'(widx(alu) * 2);
    exp_q.push_back({flt ? 1'b0 : wb, flt ? 1'b0 : (rd & ~wr), alu, data, dest});
    wb_enable_in = wb; mem_read_in = rd; mem_write_in = wr;
    alu_res_in = alu; val_rm_in = rm; dest_in = dest;
    n = -1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      t_addr[i] = sram_addr; t_dq[i] = sram_dq_out; t_we[i] = sram_we_n;
      t_oe[i] = sram_oe_n; t_dqoe[i] = sram_dq_oe; t_aluo[i] = alu_res_out;
      if (!freeze) begin n = i; break; end
    end
    check($sformatf("freeze_cycles alu=%h", alu), n, is_mem ? 2 * W : 0);
    if (n < 0) begin
      void'(exp_q.pop_front());
      idle_inputs();
      return;
    end
    if (is_mem && n > 0) check("outputs_hold_in_freeze", t_aluo[n-1], last_alu);
    for (int i = 0; i < n && is_mem; i++) begin
      check($sformatf("bus_addr[%0d]", i), 32'(t_addr[i]), 32'(a_lo + AW'(i / W)));
      check($sformatf("bus_strobes[%0d]", i), {29'd0, t_we[i], t_oe[i], t_dqoe[i]},
            wr ? {29'd0, (i % W) == W - 1, 1'b1, 1'b1} : {29'd0, 1'b1, 1'b0, 1'b0});
      if (wr) check($sformatf("bus_dq[%0d]", i), 32'(t_dq[i]), 32'(i < W ? rm[15:0] : rm[31:16]));
    end
    check("strobes_off_after", {29'd0, t_we[n], t_oe[n], t_dqoe[n]}, {29'd0, 1'b1, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("wb_enable_out", 32'(wb_enable_out), 32'(e[69]));
    check("mem_read_out", 32'(mem_read_out), 32'(e[68]));
    check("alu_res_out", alu_res_out, e[67:36]);
    check("mem_data_out", mem_data_out, e[35:4]);
    check("dest_out", 32'(dest_out), 32'(e[3:0]));
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    check("mem_fault", 32'(mem_fault), 32'(flt));
`endif
    last_data = data;
    last_alu = alu;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int kind;
    pass_cnt = 0; fail_cnt = 0; check_cnt = 0;
    last_data = 0; last_alu = 0;
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0;
    idle_inputs();
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {wb_enable_out, mem_read_out, dest_out}, 32'h0);
    check("rst_alu_data", alu_res_out | mem_data_out, 32'h0);
    check("rst_sram", {13'd0, sram_addr, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b110);
    check("rst_freeze_state", {29'd0, freeze, dbg_state}, 32'h0);
    rst = 1;
    @(posedge clk); #1;

    do_op(1, 0, 0, 32'h55, 32'h0, 4'd7);
    do_op(0, 0, 1, 32'd1028, 32'hDEADBEEF, 4'd3);
    do_op(1, 1, 0, 32'd1028, 32'h0, 4'd5);
    do_op(0, 0, 1, 32'd1032, 32'hCAFEF00D, 4'd1);
    do_op(1, 1, 0, 32'd1032, 32'h0, 4'd9);
    do_op(1, 1, 1, 32'd1036, 32'h12345678, 4'd4);
    do_op(1, 1, 0, 32'd1036, 32'h0, 4'd6);
    do_op(0, 0, 1, 32'h10, 32'hA5A55A5A, 4'd2);
    do_op(1, 1, 0, 32'h10, 32'h0, 4'd8);
    do_op(1, 1, 0, 32'd1030, 32'h0, 4'd10);
    do_op(1, 1, 0, 32'd1031, 32'h0, 4'd11);
    do_op(1, 0, 0, 32'hFFFF_0000, 32'h0, 4'd12);

    for (int k = 0; k < 10; k++) begin
      kind = $urandom_range(0, 2);
      r = $urandom;
      if (kind == 0) do_op(1'($urandom_range(0, 1)), 0, 0, $urandom, r, 4'($urandom_range(0, 15)));
      else do_op(1'($urandom_range(0, 1)), kind == 1, kind == 2,
                 BASE + 32'(4 * $urandom_range(0, 7)), r, 4'($urandom_range(0, 15)));
    end

    // reset while the HI phase of a store is on the bus
    wb_enable_in = 0; mem_read_in = 0; mem_write_in = 1;
    alu_res_in = 32'd1040; val_rm_in = 32'h0F0F1234; dest_in = 4'd2;
    repeat (3) @(negedge clk);
    check("pre_reset_hi_addr", 32'(sram_addr), 32'(AW'(widx(32'd1040) * 2 + 1)));
    #2 rst = 0;
    #1;
    check("mid_reset_strobes", {29'd0, sram_we_n, sram_dq_oe, freeze}, {29'd0, 1'b1, 1'b0, 1'b0});
    check("mid_reset_outputs", {wb_enable_out, mem_read_out, dest_out}, 32'h0);
    check("mid_reset_data", alu_res_out | mem_data_out, 32'h0);
    idle_inputs();
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check("post_reset_state", 32'(dbg_state), 32'h0);
    last_data = 0; last_alu = 0;
    do_op(1, 0, 0, 32'h77, 32'h0, 4'd13);
    do_op(1, 1, 0, 32'd1028, 32'h0, 4'd14);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
